enc_par_serializer: RTL and testbench

//  Ping-pong successor to the single-shot parity register. Captures one full RS parity block
//  (RSC_PAR_LEN symbols) from the processor on pro_finish into one of two banks.

---
 rtl/enc_par_serializer_pkg.sv | 13 +
 rtl/enc_par_bank.sv | 34 +++
 rtl/enc_par_serializer.sv | 110 +++++++++++
 tb/tb_enc_par_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_par_serializer_pkg.sv
// Shared RS parity geometry and symbol/block types for the parity serializer.
// Values mirror encoder.vh.
package enc_par_serializer_pkg;

    localparam int RSC_PAR_LEN       = 16;
    localparam int EGF_DIM           = 8;
    localparam int ENC_PAR_OUT_LANES = 4;
    localparam int ENC_PAR_BEATS     = RSC_PAR_LEN / ENC_PAR_OUT_LANES;

    typedef logic [EGF_DIM-1:0]          egf_sym_t;
    typedef egf_sym_t [RSC_PAR_LEN-1:0]  par_blk_t;

endpackage

// File: rtl/enc_par_bank.sv
// One parity block register with load enable and a combinational beat-slice select.
// Symbol 0 sits in the least significant lane of beat 0.
module enc_par_bank
    import enc_par_serializer_pkg::*;
#(
    parameter int OUT_LANES = ENC_PAR_OUT_LANES,
    parameter int BEAT_W    = 2
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  par_blk_t                     i_blk,
    input  logic [BEAT_W-1:0]            i_beat,
    output logic [OUT_LANES*EGF_DIM-1:0] o_beat_data
);

    par_blk_t r_blk;
    int       w_base;

    // NOTE: the bank is a handful of flops, not a RAM, so resetting it is cheap and
    // guarantees par_data reads 0 after reset; state always uses non-blocking updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk <= '0;
        end else if (i_load) begin
            r_blk <= i_blk;
        end
    end

    assign w_base      = int'(i_beat) * OUT_LANES;
    assign o_beat_data = r_blk[w_base +: OUT_LANES];

endmodule

// File: rtl/enc_par_serializer.sv
// Ping-pong parity serializer: two banks capture parity blocks and drain them as beats.
// Optional sticky drop flag par_ovf is built when ENC_PAR_OVF_EN is defined.
module enc_par_serializer
    import enc_par_serializer_pkg::*;
#(
    parameter int OUT_LANES = ENC_PAR_OUT_LANES
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pro_finish,
    input  logic [RSC_PAR_LEN*EGF_DIM-1:0] pro_data,
    output logic                           pro_ready,
    output logic                           par_valid,
    input  logic                           par_ready,
    output logic [OUT_LANES*EGF_DIM-1:0]   par_data,
    output logic                           par_last
`ifdef ENC_PAR_OVF_EN
    ,
    output logic                           par_ovf
`endif
);

    localparam int BEATS  = RSC_PAR_LEN / OUT_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (RSC_PAR_LEN % OUT_LANES != 0) begin : g_lane_chk
            $error("enc_par_serializer: OUT_LANES must divide RSC_PAR_LEN");
        end
    endgenerate

    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;
    logic [BEAT_W-1:0] r_beat;

    logic                         w_cap;
    logic                         w_hs;
    logic                         w_rel;
    logic [OUT_LANES*EGF_DIM-1:0] w_beat_data [2];

    assign pro_ready = (r_cnt != 2'd2);
    assign par_valid = (r_cnt != 2'd0);
    assign par_last  = par_valid && (r_beat == LAST_BEAT);

    assign w_cap = pro_finish && pro_ready;
    assign w_hs  = par_valid && par_ready;
    assign w_rel = w_hs && (r_beat == LAST_BEAT);

    enc_par_bank #(.OUT_LANES(OUT_LANES), .BEAT_W(BEAT_W)) u_bank0 (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_cap && !r_wr_ptr),
        .i_blk       (pro_data),
        .i_beat      (r_beat),
        .o_beat_data (w_beat_data[0])
    );

    enc_par_bank #(.OUT_LANES(OUT_LANES), .BEAT_W(BEAT_W)) u_bank1 (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_cap && r_wr_ptr),
        .i_blk       (pro_data),
        .i_beat      (r_beat),
        .o_beat_data (w_beat_data[1])
    );

    assign par_data = w_beat_data[r_rd_ptr];

    // Simultaneous capture and release leaves cnt alone; only the pointers move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_beat   <= '0;
        end else begin
            if (w_cap) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_rel) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_beat   <= '0;
            end else if (w_hs) begin
                r_beat   <= r_beat + 1'b1;
            end
            if (w_cap && !w_rel) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_cap && w_rel) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

`ifdef ENC_PAR_OVF_EN
    logic w_drop;
    assign w_drop = pro_finish && !pro_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_ovf <= 1'b0;
        end else if (w_drop) begin
            par_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_enc_par_serializer.sv
// Scoreboard bench for enc_par_serializer: stimulus pushes expected beats, a negedge monitor pops them.
// Exercises par_ovf when ENC_PAR_OVF_EN is defined.
module tb_enc_par_serializer;
    import enc_par_serializer_pkg::*;

    localparam int W = ENC_PAR_OUT_LANES * EGF_DIM;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic                           clk;
    logic                           rst;
    logic                           pro_finish;
    logic [RSC_PAR_LEN*EGF_DIM-1:0] pro_data;
    logic                           pro_ready;
    logic                           par_valid;
    logic                           par_ready;
    logic [W-1:0]                   par_data;
    logic                           par_last;
`ifdef ENC_PAR_OVF_EN
    logic                           par_ovf;
`endif

    enc_par_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .pro_finish (pro_finish),
        .pro_data   (pro_data),
        .pro_ready  (pro_ready),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .par_data   (par_data),
        .par_last   (par_last)
`ifdef ENC_PAR_OVF_EN
        ,
        .par_ovf    (par_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t exp_q [$];
    int    n_vec  = 0;
    int    n_err  = 0;
    int    n_hs   = 0;
    int    n_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic par_blk_t mk_blk(input logic [7:0] s);
        par_blk_t b;
        for (int i = 0; i < RSC_PAR_LEN; i++) b[i] = s + 8'(i);
        return b;
    endfunction

    function automatic logic [W-1:0] beat_of(input logic [7:0] s, input int b);
        logic [W-1:0] d;
        for (int k = 0; k < ENC_PAR_OUT_LANES; k++)
            d[k*EGF_DIM +: EGF_DIM] = s + 8'(b * ENC_PAR_OUT_LANES + k);
        return d;
    endfunction

    task automatic push_blk(input logic [7:0] s);
        for (int b = 0; b < ENC_PAR_BEATS; b++)
            exp_q.push_back('{data: beat_of(s, b), last: (b == ENC_PAR_BEATS - 1)});
    endtask

    // Single-cycle pro_finish; returns #1 after the capturing edge.
    task automatic finish_blk(input par_blk_t blk);
        @(posedge clk); #1;
        pro_finish = 1'b1;
        pro_data   = blk;
        @(posedge clk); #1;
        pro_finish = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle_valid"}, 64'(par_valid), 64'd0);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && par_valid && par_ready) begin
            n_hs++;
            if (par_last) n_last++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat at %0t",
                         par_data, par_last, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 64'(par_data), 64'(e.data));
                check("beat_last", 64'(par_last), 64'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hs0;
        int last0;
        rst        = 1'b1;
        pro_finish = 1'b0;
        pro_data   = '0;
        par_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(par_valid), 64'd0);
        check("rst_ready", 64'(pro_ready), 64'd1);
        check("rst_data",  64'(par_data),  64'd0);
        check("rst_last",  64'(par_last),  64'd0);
`ifdef ENC_PAR_OVF_EN
        check("rst_ovf",   64'(par_ovf),   64'd0);
`endif
        rst = 1'b0;

        // Straight drain of symbols 0x00..0x0F.
        par_ready = 1'b1;
        exp_q.push_back('{data: 32'h03020100, last: 1'b0});
        exp_q.push_back('{data: 32'h07060504, last: 1'b0});
        exp_q.push_back('{data: 32'h0B0A0908, last: 1'b0});
        exp_q.push_back('{data: 32'h0F0E0D0C, last: 1'b1});
        hs0 = n_hs;
        finish_blk(mk_blk(8'h00));
        check("t2_valid_n1", 64'(par_valid), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("t2_valid_n5", 64'(par_valid), 64'd0);
        check("t2_handshakes", 64'(n_hs - hs0), 64'd4);

        // Backpressure during beat 1.
        hs0 = n_hs;
        push_blk(8'h00);
        finish_blk(mk_blk(8'h00));
        @(posedge clk); #1;
        par_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t3_hold_data", 64'(par_data), 64'h07060504);
            check("t3_hold_last", 64'(par_last), 64'd0);
        end
        par_ready = 1'b1;
        wait_drain("t3");
        check("t3_handshakes", 64'(n_hs - hs0), 64'd4);

        // Overflow: A, B accepted, C dropped.
        par_ready = 1'b0;
        hs0   = n_hs;
        last0 = n_last;
        push_blk(8'h10);
        push_blk(8'h40);
        @(posedge clk); #1;
        pro_finish = 1'b1;
        pro_data   = mk_blk(8'h10);
        @(posedge clk); #1;
        check("t4_ready_after_a", 64'(pro_ready), 64'd1);
        pro_data   = mk_blk(8'h40);
        @(posedge clk); #1;
        check("t4_ready_after_b", 64'(pro_ready), 64'd0);
        pro_data   = mk_blk(8'h80);
        @(posedge clk); #1;
        pro_finish = 1'b0;
`ifdef ENC_PAR_OVF_EN
        check("t4_ovf", 64'(par_ovf), 64'd1);
`endif
        check("t4_head_a", 64'(par_data), 64'(beat_of(8'h10, 0)));
        par_ready = 1'b1;
        wait_drain("t4");
        check("t4_handshakes", 64'(n_hs - hs0), 64'd8);
        check("t4_last_pulses", 64'(n_last - last0), 64'd2);

        // Reset while a block is pending clears everything, including the drop flag.
        par_ready = 1'b0;
        finish_blk(mk_blk(8'h55));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("t1_valid", 64'(par_valid), 64'd0);
        check("t1_data",  64'(par_data),  64'd0);
        check("t1_ready", 64'(pro_ready), 64'd1);
`ifdef ENC_PAR_OVF_EN
        check("t1_ovf",   64'(par_ovf),   64'd0);
`endif
        rst = 1'b0;

        // Capture of B coincides with A's final handshake.
        par_ready = 1'b1;
        push_blk(8'h20);
        push_blk(8'hA0);
        finish_blk(mk_blk(8'h20));
        repeat (3) @(posedge clk);
        #1;
        pro_finish = 1'b1;
        pro_data   = mk_blk(8'hA0);
        @(posedge clk); #1;
        pro_finish = 1'b0;
        check("t5_valid", 64'(par_valid), 64'd1);
        check("t5_ready", 64'(pro_ready), 64'd1);
        check("t5_b_beat0", 64'(par_data), 64'(beat_of(8'hA0, 0)));
        wait_drain("t5");

        // Reset after two beats of A with B queued, then a fresh block C.
        push_blk(8'h30);
        @(posedge clk); #1;
        pro_finish = 1'b1;
        pro_data   = mk_blk(8'h30);
        @(posedge clk); #1;
        pro_data   = mk_blk(8'hC0);
        @(posedge clk); #1;
        pro_finish = 1'b0;
        @(posedge clk); #1;
        check("t6_pre_rst_left", 64'(exp_q.size()), 64'd2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_valid", 64'(par_valid), 64'd0);
        push_blk(8'hE0);
        finish_blk(mk_blk(8'hE0));
        check("t6_c_valid", 64'(par_valid), 64'd1);
        check("t6_c_beat0", 64'(par_data), 64'(beat_of(8'hE0, 0)));
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
